// File: rtl/serial_stream_arbiter.sv
// Round-robin arbiter that serialises one requester's burst into a shared
// serial detector and reports the number of detector hits per burst.
// Ports: clk, reset_n (async, active low); req/len/payload per requester in;
// gnt one-hot grant, busy; det_reset/det_x1 to detector, det_outp from it;
// done pulse with done_id and hit_cnt, both held until the next done.
module serial_stream_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 64,
  parameter int DET_LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   req,
  input  logic [27:0]  len,
  input  logic [255:0] payload,
  output logic [3:0]   gnt,
  output logic         busy,
  output logic         det_reset,
  output logic         det_x1,
  input  logic         det_outp,
  output logic         done,
  output logic [1:0]   done_id,
  output logic [6:0]   hit_cnt
);

  localparam logic [6:0] LMAX = 7'(MAX_LEN);
  localparam logic [1:0] DL   = 2'(DET_LAT);
  localparam logic [6:0] DL7  = 7'(DET_LAT);

  typedef enum logic [2:0] {
    IDLE, CLR, SHIFT, DRAIN, DONE
  } state_t;

  state_t      state, state_d;
  logic [63:0] sh, sh_d;
  logic [6:0]  lq, lq_d;
  logic [6:0]  cnt, cnt_d;
  logic [1:0]  dcnt, dcnt_d;
  logic [6:0]  t, t_d;
  logic [6:0]  acc, acc_d;
  logic [1:0]  ptr, ptr_d;
  logic [1:0]  win, win_d;
  logic [3:0]  gnt_d;
  logic        done_d, x1_d;
  logic [1:0]  done_id_d;
  logic [6:0]  hit_d;

  logic        found;
  logic [1:0]  pick, idx;
  logic [6:0]  raw, eff;
  logic [63:0] pay;
  logic        counting;

  always_comb begin
    state_d   = state;
    sh_d      = sh;
    lq_d      = lq;
    cnt_d     = cnt;
    dcnt_d    = dcnt;
    t_d       = t;
    acc_d     = acc;
    ptr_d     = ptr;
    win_d     = win;
    gnt_d     = gnt;
    done_d    = 1'b0;
    done_id_d = done_id;
    hit_d     = hit_cnt;
    x1_d      = 1'b0;
    found     = 1'b0;
    pick      = ptr;
    idx       = ptr;

    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    raw = len[int'(pick)*7 +: 7];
    eff = (raw > LMAX) ? LMAX : raw;
    pay = payload[int'(pick)*64 +: 64];
    // Detector output is valid DET_LAT cycles after each shifted bit.
    counting = (t >= DL7);

    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << pick;
          win_d   = pick;
          ptr_d   = pick + 2'd1;
          lq_d    = eff;
          // Left-align so bit L-1 of the burst sits at bit 63.
          sh_d    = pay << (7'd64 - eff);
          acc_d   = 7'd0;
          state_d = CLR;
        end
      end
      CLR: begin
        t_d = 7'd0;
        if (lq == 7'd0) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
          x1_d    = sh[63];
          sh_d    = sh << 1;
          cnt_d   = lq - 7'd1;
        end
      end
      SHIFT: begin
        t_d = t + 7'd1;
        if (counting && det_outp) acc_d = acc + 7'd1;
        if (cnt == 7'd0) begin
          state_d = (DL == 2'd0) ? DONE : DRAIN;
          dcnt_d  = DL - 2'd1;
        end else begin
          x1_d  = sh[63];
          sh_d  = sh << 1;
          cnt_d = cnt - 7'd1;
        end
      end
      DRAIN: begin
        t_d = t + 7'd1;
        if (counting && det_outp) acc_d = acc + 7'd1;
        if (dcnt == 2'd0) state_d = DONE;
        else dcnt_d = dcnt - 2'd1;
      end
      DONE: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE) begin
      done_d    = 1'b1;
      done_id_d = win;
      hit_d     = acc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sh        <= '0;
      lq        <= '0;
      cnt       <= '0;
      dcnt      <= '0;
      t         <= '0;
      acc       <= '0;
      ptr       <= '0;
      win       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      det_reset <= 1'b1;
      det_x1    <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_cnt   <= '0;
    end else begin
      state     <= state_d;
      sh        <= sh_d;
      lq        <= lq_d;
      cnt       <= cnt_d;
      dcnt      <= dcnt_d;
      t         <= t_d;
      acc       <= acc_d;
      ptr       <= ptr_d;
      win       <= win_d;
      gnt       <= gnt_d;
      busy      <= (state_d != IDLE);
      det_reset <= (state_d == IDLE) || (state_d == CLR);
      det_x1    <= x1_d;
      done      <= done_d;
      done_id   <= done_id_d;
      hit_cnt   <= hit_d;
    end
  end

endmodule

// File: tb/tb_serial_stream_arbiter.sv
// Bench for serial_stream_arbiter with a one-cycle registered stub detector.
// Table of bursts plus hand sequences for timing, abort and mid-burst edits.
module tb_serial_stream_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req = '0;
  logic [27:0]  len = '0;
  logic [255:0] payload = '0;
  logic [3:0]   gnt;
  logic         busy, det_reset, det_x1, det_outp, done;
  logic [1:0]   done_id;
  logic [6:0]   hit_cnt;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_stream_arbiter #(.NUM_REQ(4), .MAX_LEN(64), .DET_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .len(len),
    .payload(payload), .gnt(gnt), .busy(busy),
    .det_reset(det_reset), .det_x1(det_x1), .det_outp(det_outp),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) det_outp <= 1'b0;
    else if (det_reset) det_outp <= 1'b0;
    else det_outp <= det_x1;
  end

  typedef struct {
    logic [3:0]  rq;
    logic [6:0]  l;
    logic [63:0] p;
    logic [1:0]  id;
    logic [6:0]  hit;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input string n);
    bit got = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (gnt != 4'b0000) begin
        got = 1;
        break;
      end
    end
    if (!got) chk({n, "_gnt_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string n, input logic [1:0] eid,
                           input logic [6:0] ehit);
    bit got = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk({n, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({n, "_id"}, 64'(done_id), 64'(eid));
      chk({n, "_hit"}, 64'(hit_cnt), 64'(ehit));
    end
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'b1111, 7'd1, 64'h1, 2'(i), 7'd1};
    tbl[8]  = '{4'b0001, 7'd8,   64'hA5, 2'd0, 7'd4};
    tbl[9]  = '{4'b0010, 7'd0,   '1,     2'd1, 7'd0};
    tbl[10] = '{4'b0100, 7'd100, '1,     2'd2, 7'd64};
    tbl[11] = '{4'b1010, 7'd12,  64'hF0F0, 2'd3, 7'd4};
    tbl[12] = '{4'b1010, 7'd5,   64'h1F, 2'd1, 7'd5};
    tbl[13] = '{4'b0101, 7'd64,  64'h8000_0000_0000_0001, 2'd2, 7'd2};

    // Reset state
    step();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);
    chk("rst_hit", 64'(hit_cnt), 64'd0);
    chk("rst_x1", 64'(det_x1), 64'd0);
    chk("rst_det_reset", 64'(det_reset), 64'd1);
    step();
    reset_n = 1'b1;

    // Single burst, cycle by cycle
    req = 4'b0001;
    len = {4{7'd8}};
    payload = {4{64'hA5}};
    wait_gnt("a5");
    req = 4'b0000;
    chk("a5_gnt", 64'(gnt), 64'b0001);
    chk("a5_clr_det_reset", 64'(det_reset), 64'd1);
    chk("a5_clr_busy", 64'(busy), 64'd1);
    for (int b = 0; b < 8; b++) begin
      step();
      chk($sformatf("a5_bit%0d", b), 64'(det_x1), 64'(a5[7-b]));
      chk($sformatf("a5_dr%0d", b), 64'(det_reset), 64'd0);
    end
    step();
    chk("a5_drain_x1", 64'(det_x1), 64'd0);
    chk("a5_drain_done", 64'(done), 64'd0);
    step();
    chk("a5_done", 64'(done), 64'd1);
    chk("a5_done_id", 64'(done_id), 64'd0);
    chk("a5_hit", 64'(hit_cnt), 64'd4);
    chk("a5_done_gnt", 64'(gnt), 64'b0001);
    step();
    chk("a5_post_done", 64'(done), 64'd0);
    chk("a5_hold_hit", 64'(hit_cnt), 64'd4);
    chk("a5_post_gnt", 64'(gnt), 64'd0);
    chk("a5_post_busy", 64'(busy), 64'd0);

    // Reset pulse in IDLE restores the round-robin pointer
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      req = tbl[i].rq;
      len = {4{tbl[i].l}};
      payload = {4{tbl[i].p}};
      wait_done($sformatf("vec%0d", i), tbl[i].id, tbl[i].hit);
    end
    req = 4'b0000;
    step();
    step();

    // Abort mid-SHIFT, then pointer restarts at 0
    req = 4'b0010;
    len = {4{7'd32}};
    payload = '0;
    wait_gnt("abort");
    req = 4'b0000;
    chk("abort_gnt", 64'(gnt), 64'b0010);
    for (int c = 0; c < 5; c++) step();
    reset_n = 1'b0;
    #1;
    chk("abort_gnt0", 64'(gnt), 64'd0);
    chk("abort_det_reset", 64'(det_reset), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done) chk("abort_no_done", 64'(done), 64'd0);
    end
    req = 4'b1111;
    wait_gnt("rr0");
    req = 4'b0000;
    chk("rr0_gnt", 64'(gnt), 64'b0001);
    wait_done("rr0", 2'd0, 7'd0);

    // req dropped and payload/len changed mid-burst
    req = 4'b0100;
    len = {4{7'd16}};
    payload = {4{64'h00FF}};
    wait_gnt("mid");
    chk("mid_gnt", 64'(gnt), 64'b0100);
    for (int c = 0; c < 3; c++) step();
    req = 4'b0000;
    payload[128 +: 64] = '1;
    len = '0;
    step();
    chk("mid_gnt_hold", 64'(gnt), 64'b0100);
    wait_done("mid", 2'd2, 7'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
